row_fetch: RTL and testbench



---
 rtl/row_fetch.sv | 149 ++++++++++++++
 tb/tb_row_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/row_fetch.sv
// Fetches one display row (ROW_ELEM pixels) from the frame buffer into a shadow register
// and swaps it atomically into row_out once complete; aborts and restarts on a new request.
module row_fetch #(
    parameter int unsigned COLOR_COUNT     = 3,
    parameter int unsigned COLOR_BITS      = 4,
    parameter int unsigned COL_ADDR_BITS   = 6,
    parameter int unsigned ROW_ADDR_BITS   = 4,
    localparam int unsigned ROW_ELEM       = 2 ** COL_ADDR_BITS,
    localparam int unsigned ROW_DAT_WIDTH  = ROW_ELEM * COLOR_BITS * COLOR_COUNT,
    localparam int unsigned PIX_WIDTH      = COLOR_COUNT * COLOR_BITS,
    localparam int unsigned ADDR_WIDTH     = ROW_ADDR_BITS + COL_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ROW_ADDR_BITS-1:0] next_row,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [PIX_WIDTH-1:0]     mem_rd_data,
    output logic [ROW_DAT_WIDTH-1:0] row_out,
    output logic [ROW_ADDR_BITS-1:0] row_id,
    output logic                     row_valid,
    output logic                     busy
);

    localparam int unsigned PLANE_WIDTH = ROW_ELEM * COLOR_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [ROW_ADDR_BITS-1:0]   fetch_row;
    logic [COL_ADDR_BITS-1:0]   col;
    logic [COL_ADDR_BITS-1:0]   col_d;
    logic                       rd_en_d;
    logic                       need_fetch;
    logic [ROW_DAT_WIDTH-1:0]   shadow;
    logic [ROW_DAT_WIDTH-1:0]   shadow_next;
    logic                       row_changed;
    logic                       last_col;
    logic                       start_c;
    logic                       swap_c;

    assign row_changed = (next_row != fetch_row);
    assign last_col    = (col == COL_ADDR_BITS'(ROW_ELEM - 1));
    assign mem_addr    = {fetch_row, col};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a changed request always restarts the fetch
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (need_fetch || row_changed) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (row_changed) begin
                    state_next = FETCH;
                end else if (last_col) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = row_changed ? FETCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control strobes: start (latch row, col 0) and swap (shadow -> row_out)
    always_comb begin
        start_c = 1'b0;
        swap_c  = 1'b0;
        case (state)
            IDLE:  start_c = need_fetch || row_changed;
            FETCH: start_c = row_changed;
            DRAIN: begin
                start_c = row_changed;
                swap_c  = !row_changed;
            end
            default: begin
                start_c = 1'b0;
                swap_c  = 1'b0;
            end
        endcase
    end

    // Read-data capture: slot col_d takes the pixel returned for the previous read
    for (genvar k = 0; k < ROW_ELEM; k++) begin : g_slot
        for (genvar c = 0; c < COLOR_COUNT; c++) begin : g_color
            assign shadow_next[c*PLANE_WIDTH + k*COLOR_BITS +: COLOR_BITS] =
                (rd_en_d && (col_d == COL_ADDR_BITS'(k)))
                    ? mem_rd_data[c*COLOR_BITS +: COLOR_BITS]
                    : shadow[c*PLANE_WIDTH + k*COLOR_BITS +: COLOR_BITS];
        end
    end

    // Shadow holds only in-flight data and is never visible before a full fetch
    always_ff @(posedge clk) begin
        shadow <= shadow_next;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_row  <= '0;
            col        <= '0;
            col_d      <= '0;
            rd_en_d    <= 1'b0;
            need_fetch <= 1'b1;
            mem_rd_en  <= 1'b0;
            busy       <= 1'b0;
            row_out    <= '0;
            row_id     <= '0;
            row_valid  <= 1'b0;
        end else begin
            rd_en_d   <= mem_rd_en;
            col_d     <= col;
            mem_rd_en <= (state_next == FETCH);
            busy      <= (state_next != IDLE);
            if (start_c) begin
                fetch_row <= next_row;
                col       <= '0;
            end else if (state == FETCH) begin
                col <= col + COL_ADDR_BITS'(1);
            end
            if (swap_c) begin
                row_out    <= shadow_next;
                row_id     <= fetch_row;
                row_valid  <= 1'b1;
                need_fetch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_row_fetch.sv
// Randomized bench for row_fetch: a request/latency-level reference model predicts
// row_out, row_id, row_valid, busy and the read stream every cycle.
module tb_row_fetch;

    localparam int unsigned CB    = 4;
    localparam int unsigned CC    = 3;
    localparam int unsigned CA    = 6;
    localparam int unsigned RA    = 4;
    localparam int unsigned RE    = 64;
    localparam int unsigned RW    = RE * CB * CC;
    localparam int unsigned PLANE = RE * CB;
    localparam int unsigned AW    = RA + CA;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RA-1:0] next_row;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_rd_data;
    logic [RW-1:0] row_out;
    logic [RA-1:0] row_id;
    logic          row_valid;
    logic          busy;

    always #5 clk = ~clk;

    row_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_row    (next_row),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .row_out     (row_out),
        .row_id      (row_id),
        .row_valid   (row_valid),
        .busy        (busy)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          mode  = 0;
    int unsigned seed  = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mem_fn(input logic [AW-1:0] a);
        case (mode)
            0:       return 12'(a);
            1:       return 12'hA00;
            default: return 12'(32'(a) * 37 + seed);
        endcase
    endfunction

    // One-cycle-latency memory
    always @(posedge clk) mem_rd_data <= mem_fn(mem_addr);

    function automatic logic [RW-1:0] build_row(input logic [RA-1:0] r);
        logic [RW-1:0] v;
        logic [11:0]   px;
        v = '0;
        for (int k = 0; k < int'(RE); k++) begin
            px = mem_fn({r, CA'(k)});
            for (int c = 0; c < int'(CC); c++) begin
                v[c*PLANE + k*CB +: CB] = px[c*CB +: CB];
            end
        end
        return v;
    endfunction

    // Reference model: a request starts a 65-cycle window; reads occupy its first 64
    // cycles; a different next_row at any edge of the window restarts it.
    bit            m_init   = 1'b0;
    bit            m_rst    = 1'b0;
    bit            m_active = 1'b0;
    bit            m_need   = 1'b1;
    int            m_count  = 0;
    logic [RA-1:0] m_target = '0;
    logic [RW-1:0] e_row    = '0;
    logic [RA-1:0] e_id     = '0;
    logic          e_valid  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rst    = 1'b1;
            m_active = 1'b0;
            m_need   = 1'b1;
            m_count  = 0;
            m_target = '0;
            e_row    = '0;
            e_id     = '0;
            e_valid  = 1'b0;
        end else begin
            m_rst = 1'b0;
            if (!m_active) begin
                if (m_need || next_row != m_target) begin
                    m_target = next_row;
                    m_active = 1'b1;
                    m_count  = 0;
                end
            end else if (next_row != m_target) begin
                m_target = next_row;
                m_count  = 0;
            end else begin
                m_count++;
                if (m_count == 65) begin
                    e_row    = build_row(m_target);
                    e_id     = m_target;
                    e_valid  = 1'b1;
                    m_active = 1'b0;
                    m_need   = 1'b0;
                end
            end
        end
        m_init = 1'b1;
    end

    // Per-cycle comparison, sampled mid-cycle
    always @(negedge clk) begin
        logic          e_rd;
        logic [AW-1:0] e_addr;
        if (m_init) begin
            e_rd   = m_active && (m_count < 64);
            e_addr = m_rst ? AW'(0) : {m_target, CA'(m_count)};
            check("row_valid", RW'(row_valid), RW'(e_valid));
            check("row_id", RW'(row_id), RW'(e_id));
            check("busy", RW'(busy), RW'(m_active));
            check("mem_rd_en", RW'(mem_rd_en), RW'(e_rd));
            if (e_rd || m_rst) check("mem_addr", RW'(mem_addr), RW'(e_addr));
            check("row_out", row_out, e_row);
        end
    end

    // Wait (bounded) until the model is in the given cycle of a fetch window
    task automatic wait_count(input int n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (m_active && m_count == n) found = 1'b1;
        end
        check("wait_timeout", RW'(found), RW'(1));
    endtask

    initial begin
        rst_n    = 1'b0;
        next_row = 4'd3;
        mode     = 0;
        seed     = $urandom;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (75) @(negedge clk);

        mode     = 1;
        next_row = 4'd0;
        repeat (75) @(negedge clk);

        mode     = 2;
        next_row = 4'd5;
        repeat (275) @(negedge clk);

        next_row = 4'd1;
        wait_count(30);
        next_row = 4'd2;
        repeat (75) @(negedge clk);

        next_row = 4'd7;
        wait_count(64);
        next_row = 4'd8;
        repeat (75) @(negedge clk);

        next_row = 4'd9;
        wait_count(40);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (75) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            next_row = RA'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 90)) @(negedge clk);
        end
        repeat (80) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
